lcd_bus_scheduler: RTL

Sequences every byte sent to the 16x2 HD44780-style character LCD.
- Requesters (init sequencer, ASCII formatter) push {RS, byte} entries through a valid/ready port into a small FIFO.
- The block drives RS/RW/E/Data_Bus with correct setup, pulse and hold timing, then waits the command-dependent execution delay before the next byte.
- Tracks cursor column and inserts line-change commands automatically, so requesters never count characters.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_cmd_fifo.sv | 73 +++++++
 rtl/lcd_bus_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 bus scheduler: command byte constants,
// scheduler FSM encoding, the 9-bit request entry layout {rs, byte}, and a
// couple of small helpers used for counter sizing and wait selection.
// -----------------------------------------------------------------------------
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
  localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CMD_DDRAM    = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_t;

  // One queued transfer: rs=0 command, rs=1 character data.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear/home (and the undocumented 0x03 alias of home) need the long wait.
  function automatic logic is_long_cmd(input lcd_entry_t e);
    return !e.rs && ((e.data == LCD_CMD_CLEAR) || (e.data == LCD_CMD_HOME) ||
                     (e.data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// -----------------------------------------------------------------------------
// lcd_cmd_fifo
// Synchronous request FIFO of lcd_entry_t, FIFO_DEPTH deep (power of two).
// Head entry is presented combinationally on o_dout so the scheduler can pop
// it into its shadow register in the same cycle it decides to start.
// Ports:
//   clk, reset_n     clock, async active-low reset (empties the FIFO)
//   i_clr            sync clear; overrides push and pop in the same cycle
//   i_push, i_din    write request (ignored when full)
//   i_pop            read request (ignored when empty)
//   o_dout           head entry
//   o_full, o_empty  status from the registered count
//   o_count          number of stored entries
// -----------------------------------------------------------------------------
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_clr,
  input  logic                        i_push,
  input  lcd_entry_t                  i_din,
  input  logic                        i_pop,
  output lcd_entry_t                  o_dout,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  lcd_entry_t      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full && !i_clr;
  assign w_pop_ok  = i_pop && !o_empty && !i_clr;

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_bus_scheduler
// Serialises {RS, byte} requests onto an HD44780 parallel bus with setup,
// E-pulse, hold and execution-wait timing, and tracks the cursor column so
// that line-change commands are inserted automatically at columns 16 and 32.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   wr_valid/wr_rs/wr_data        request port, accepted when wr_ready
//   wr_ready                      request FIFO not full
//   flush                         sync: drop queued entries and pending insert
//   RS, RW, E, Data_Bus           LCD pins (RW tied low, others registered)
//   busy                          transfer running or work outstanding
//   xfer_done                     1-cycle pulse at the end of each byte's wait
//   cursor_col                    tracked DDRAM position 0..31
// -----------------------------------------------------------------------------
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int SETUP_CYC     = 2,
  parameter int E_HIGH_CYC    = 12,
  parameter int HOLD_CYC      = 2,
  parameter int CMD_WAIT_CYC  = 2500,
  parameter int LONG_WAIT_CYC = 100000,
  parameter bit AUTO_WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       flush,
  output logic       RS,
  output logic       RW,
  output logic       E,
  output logic [7:0] Data_Bus,
  output logic       busy,
  output logic       xfer_done,
  output logic [4:0] cursor_col
);

  localparam int CNT_MAX = max_int(max_int(SETUP_CYC, E_HIGH_CYC),
                                   max_int(HOLD_CYC, max_int(CMD_WAIT_CYC, LONG_WAIT_CYC)));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  lcd_state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]            r_cnt, w_cnt_load;
  lcd_entry_t                  r_shadow;
  logic                        r_pending_vld, r_pending_line2;
  logic [4:0]                  r_cursor, w_cursor_next;
  logic                        r_rs, r_e, r_done;
  logic [7:0]                  r_data;
  logic                        w_pop, w_take_insert, w_hold_exit, w_wrap_set;
  lcd_entry_t                  w_push_entry, w_fifo_dout;
  logic                        w_full, w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

  assign w_push_entry = '{rs: wr_rs, data: wr_data};

  lcd_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (flush),
    .i_push  (wr_valid),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  // Next state, plus the reload value for whichever state is being entered.
  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    w_take_insert = 1'b0;
    w_cnt_load    = '0;
    case (r_state)
      ST_IDLE: begin
        // Nothing starts on a flush edge: the queue and insert vanish with it.
        if (!flush) begin
          if (r_pending_vld) begin
            w_take_insert = 1'b1;
            w_state_next  = ST_SETUP;
          end else if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = ST_SETUP;
          end
        end
      end
      ST_SETUP: if (r_cnt == '0) w_state_next = ST_PULSE;
      ST_PULSE: if (r_cnt == '0) w_state_next = ST_HOLD;
      ST_HOLD:  if (r_cnt == '0) w_state_next = ST_WAIT;
      ST_WAIT:  if (r_cnt == '0) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
    case (w_state_next)
      ST_SETUP: w_cnt_load = CNT_W'(SETUP_CYC - 1);
      ST_PULSE: w_cnt_load = CNT_W'(E_HIGH_CYC - 1);
      ST_HOLD:  w_cnt_load = CNT_W'(HOLD_CYC - 1);
      ST_WAIT:  w_cnt_load = is_long_cmd(r_shadow) ? CNT_W'(LONG_WAIT_CYC - 1)
                                                   : CNT_W'(CMD_WAIT_CYC - 1);
      default:  w_cnt_load = '0;
    endcase
  end

  // Column the LCD's address counter will hold once the current byte executes.
  always_comb begin
    w_cursor_next = r_cursor;
    if (r_shadow.rs) begin
      w_cursor_next = r_cursor + 5'd1;
    end else if ((r_shadow.data == LCD_CMD_CLEAR) || (r_shadow.data == LCD_CMD_HOME)) begin
      w_cursor_next = '0;
    end else if (r_shadow.data[7]) begin
      w_cursor_next = {r_shadow.data[6], r_shadow.data[3:0]};
    end
  end

  assign w_hold_exit = (r_state == ST_HOLD) && (r_cnt == '0);
  assign w_wrap_set  = AUTO_WRAP && w_hold_exit && r_shadow.rs &&
                       ((w_cursor_next == 5'd16) || (w_cursor_next == 5'd0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt           <= '0;
      r_shadow        <= '0;
      r_cursor        <= '0;
      r_pending_vld   <= 1'b0;
      r_pending_line2 <= 1'b0;
    end else begin
      if (w_state_next != r_state) r_cnt <= w_cnt_load;
      else if (r_cnt != '0)        r_cnt <= r_cnt - CNT_W'(1);

      if (w_pop)              r_shadow <= w_fifo_dout;
      else if (w_take_insert) r_shadow <= '{rs: 1'b0,
                                            data: r_pending_line2 ? LCD_CMD_LINE2 : LCD_CMD_DDRAM};

      if (w_hold_exit) r_cursor <= w_cursor_next;

      if (flush) begin
        r_pending_vld <= 1'b0;
      end else if (w_wrap_set) begin
        r_pending_vld   <= 1'b1;
        r_pending_line2 <= (w_cursor_next == 5'd16);
      end else if (w_take_insert) begin
        r_pending_vld <= 1'b0;
      end
    end
  end

  // Pins follow the state by one cycle; the bus keeps its value outside SETUP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rs   <= 1'b0;
      r_data <= '0;
      r_e    <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (r_state == ST_SETUP) begin
        r_rs   <= r_shadow.rs;
        r_data <= r_shadow.data;
      end
      r_e    <= (r_state == ST_PULSE);
      r_done <= (r_state == ST_WAIT) && (r_cnt == '0);
    end
  end

  assign RS         = r_rs;
  assign RW         = 1'b0;
  assign E          = r_e;
  assign Data_Bus   = r_data;
  assign xfer_done  = r_done;
  assign cursor_col = r_cursor;
  assign wr_ready   = !w_full;
  // A queued line-change insert is outstanding work too.
  assign busy       = (r_state != ST_IDLE) || (w_fifo_count != '0) || r_pending_vld;

endmodule
